// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types and constants for the writeback port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  localparam int WAIT_W    = 8;
  // Widest XLEN the request struct can carry; narrower payloads are zero-padded.
  localparam int WB_DATA_W = 64;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FPU  = 2'd2,
    SRC_MDU  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [4:0]           rd;
    logic                 fp;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Integer x0 is hard-wired to zero, so that write is dropped.
  function automatic logic wb_write_en(input logic fp, input logic [4:0] rd);
    return fp || (rd != 5'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Writeback sources, register-file port and stall bundle.
//               Optional perf_stall_cnt present only with WBARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);

  logic            hold;

  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic            pipe_fp;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_stall;

  logic            fpu_valid;
  logic            fpu_ready;
  logic [4:0]      fpu_rd;
  logic            fpu_fp;
  logic [XLEN-1:0] fpu_data;

  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;

  logic            rf_we;
  logic            rf_fp;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

`ifdef WBARB_PERF_EN
  logic [31:0]     perf_stall_cnt;
`endif

  // Arbiter side
  modport slave (
    input  hold,
    input  pipe_valid, pipe_rd, pipe_fp, pipe_data,
    output pipe_stall,
    input  fpu_valid, fpu_rd, fpu_fp, fpu_data,
    output fpu_ready,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    output rf_we, rf_fp, rf_rd, rf_wdata
`ifdef WBARB_PERF_EN
    , output perf_stall_cnt
`endif
  );

  // Source / register-file side
  modport master (
    output hold,
    output pipe_valid, pipe_rd, pipe_fp, pipe_data,
    input  pipe_stall,
    output fpu_valid, fpu_rd, fpu_fp, fpu_data,
    input  fpu_ready,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    input  rf_we, rf_fp, rf_rd, rf_wdata
`ifdef WBARB_PERF_EN
    , input perf_stall_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter_rr_pick2.sv
// ============================================================================
// Module      : wb_rr_pick2
// Description : Two-requester round-robin picker; owns the rr pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_pick2
  import wb_arb_pkg::*;
(
  input  wire logic clk,
  input  wire logic Rst,
  input  wire logic i_en,
  input  wire logic i_req0,
  input  wire logic i_req1,
  output logic      o_gnt0,
  output logic      o_gnt1
);

  // 0 prefers requester 0 (FPU), 1 prefers requester 1 (MDU)
  logic r_ptr;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        o_gnt0 = ~r_ptr;
        o_gnt1 = r_ptr;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_ptr <= 1'b0;
    end else if (o_gnt0) begin
      r_ptr <= 1'b1;
    end else if (o_gnt1) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module      : wb_port_arbiter
// Description : Register-file write-port arbiter for pipeline, FPU and MDU
//               writebacks with starvation-bounded pipeline priority.
//               Define WBARB_PERF_EN to add the starvation-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = 32
) (
  input  wire logic         clk,
  input  wire logic         Rst,
  wb_port_arbiter_if.slave  bus
);

  localparam logic [WAIT_W-1:0] c_starve_limit = WAIT_W'(STARVE_LIMIT);

  wb_req_t           w_pipe_req;
  wb_req_t           w_fpu_req;
  wb_req_t           w_mdu_req;
  wb_req_t           w_win;
  wb_src_e           w_src;

  logic              w_any_aux;
  logic              w_force_aux;
  logic              w_pipe_gnt;
  logic              w_aux_en;
  logic              w_fpu_gnt;
  logic              w_mdu_gnt;
  logic              w_pipe_stall;
  logic              w_unused_pad;

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_rf_we;
  logic              r_rf_fp;
  logic [4:0]        r_rf_rd;
  logic [XLEN-1:0]   r_rf_wdata;

  always_comb begin
    w_pipe_req       = '0;
    w_pipe_req.valid = bus.pipe_valid;
    w_pipe_req.rd    = bus.pipe_rd;
    w_pipe_req.fp    = bus.pipe_fp;
    w_pipe_req.data  = WB_DATA_W'(bus.pipe_data);

    w_fpu_req        = '0;
    w_fpu_req.valid  = bus.fpu_valid;
    w_fpu_req.rd     = bus.fpu_rd;
    w_fpu_req.fp     = bus.fpu_fp;
    w_fpu_req.data   = WB_DATA_W'(bus.fpu_data);

    // MDU only ever writes the integer file
    w_mdu_req        = '0;
    w_mdu_req.valid  = bus.mdu_valid;
    w_mdu_req.rd     = bus.mdu_rd;
    w_mdu_req.fp     = 1'b0;
    w_mdu_req.data   = WB_DATA_W'(bus.mdu_data);
  end

  assign w_any_aux    = w_fpu_req.valid | w_mdu_req.valid;
  assign w_force_aux  = (r_wait_cnt >= c_starve_limit) & w_any_aux;
  assign w_pipe_gnt   = ~bus.hold & w_pipe_req.valid & ~w_force_aux;
  assign w_aux_en     = ~bus.hold & ~w_pipe_gnt;
  assign w_pipe_stall = ~bus.hold & w_pipe_req.valid & w_force_aux;

  wb_rr_pick2 u_rr_pick2 (
    .clk    (clk),
    .Rst    (Rst),
    .i_en   (w_aux_en),
    .i_req0 (w_fpu_req.valid),
    .i_req1 (w_mdu_req.valid),
    .o_gnt0 (w_fpu_gnt),
    .o_gnt1 (w_mdu_gnt)
  );

  always_comb begin
    w_src = SRC_NONE;
    if (w_pipe_gnt) begin
      w_src = SRC_PIPE;
    end else if (w_fpu_gnt) begin
      w_src = SRC_FPU;
    end else if (w_mdu_gnt) begin
      w_src = SRC_MDU;
    end
  end

  always_comb begin
    w_win = '0;
    case (w_src)
      SRC_PIPE: w_win = w_pipe_req;
      SRC_FPU:  w_win = w_fpu_req;
      SRC_MDU:  w_win = w_mdu_req;
      default:  w_win = '0;
    endcase
  end

  // Bits above XLEN are always zero padding
  assign w_unused_pad = ^w_win.data;

  // Waits only count while an aux result is actually being held off
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_wait_cnt <= '0;
    end else if (!bus.hold) begin
      if (w_fpu_gnt || w_mdu_gnt || !w_any_aux) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != {WAIT_W{1'b1}}) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_rf_we    <= 1'b0;
      r_rf_fp    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else if (w_win.valid) begin
      r_rf_we    <= wb_write_en(w_win.fp, w_win.rd);
      r_rf_fp    <= w_win.fp;
      r_rf_rd    <= w_win.rd;
      r_rf_wdata <= w_win.data[XLEN-1:0];
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign bus.pipe_stall = w_pipe_stall;
  assign bus.fpu_ready  = w_fpu_gnt;
  assign bus.mdu_ready  = w_mdu_gnt;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_fp      = r_rf_fp;
  assign bus.rf_rd      = r_rf_rd;
  assign bus.rf_wdata   = r_rf_wdata;

`ifdef WBARB_PERF_EN
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_perf_stall_cnt <= '0;
    end else if (w_pipe_stall) begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench: vector table, starvation sequence,
//               randomized run against a reference model, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int XLEN  = 32;
  localparam int LIMIT = 8;

  typedef struct {
    logic        hold;
    logic        pv;
    logic [4:0]  prd;
    logic        pfp;
    logic [31:0] pdata;
    logic        fv;
    logic [4:0]  frd;
    logic        ffp;
    logic [31:0] fdata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [2:0]  e_comb;   // {pipe_stall, fpu_ready, mdu_ready}
    logic [38:0] e_rf;     // {rf_we, rf_rd, rf_fp, rf_wdata}
  } vec_t;

  logic clk = 1'b0;
  logic Rst = 1'b1;

  wb_port_arbiter_if #(.XLEN(XLEN)) bus();

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(XLEN)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

`ifdef WBARB_PERF_EN
  wb_port_arbiter_if #(.XLEN(XLEN)) bus0();

  wb_port_arbiter #(.STARVE_LIMIT(0), .XLEN(XLEN)) dut0 (
    .clk (clk),
    .Rst (Rst),
    .bus (bus0)
  );
`endif

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic stim_t st(input logic hold,
                               input logic pv, input logic [4:0] prd, input logic pfp, input logic [31:0] pdata,
                               input logic fv, input logic [4:0] frd, input logic ffp, input logic [31:0] fdata,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    stim_t s;
    s.hold = hold; s.pv = pv; s.prd = prd; s.pfp = pfp; s.pdata = pdata;
    s.fv = fv; s.frd = frd; s.ffp = ffp; s.fdata = fdata;
    s.mv = mv; s.mrd = mrd; s.mdata = mdata;
    return s;
  endfunction

  function automatic vec_t mk(input stim_t s, input logic [2:0] c,
                              input logic we, input logic [4:0] rd, input logic fp, input logic [31:0] d);
    vec_t v;
    v.s = s; v.e_comb = c; v.e_rf = {we, rd, fp, d};
    return v;
  endfunction

  task automatic drive(input stim_t s);
    bus.hold = s.hold;
    bus.pipe_valid = s.pv; bus.pipe_rd = s.prd; bus.pipe_fp = s.pfp; bus.pipe_data = s.pdata;
    bus.fpu_valid = s.fv; bus.fpu_rd = s.frd; bus.fpu_fp = s.ffp; bus.fpu_data = s.fdata;
    bus.mdu_valid = s.mv; bus.mdu_rd = s.mrd; bus.mdu_data = s.mdata;
  endtask

  function automatic logic [2:0] get_comb();
    return {bus.pipe_stall, bus.fpu_ready, bus.mdu_ready};
  endfunction

  function automatic logic [38:0] get_rf();
    return {bus.rf_we, bus.rf_rd, bus.rf_fp, bus.rf_wdata};
  endfunction

  task automatic do_reset();
    Rst = 1'b1;
    drive(st(0, 0,0,0,0, 0,0,0,0, 0,0,0));
    repeat (2) @(posedge clk);
    #1;
    Rst = 1'b0;
  endtask

  vec_t        vecs[12];
  stim_t       s;
  stim_t       idle;
  logic [31:0] pd, fd;
  logic        exp_b;
  int          p, k, src;
  logic        m_force, p_keep, f_keep, m_keep;
  int          m_wait, m_ptr;
  logic        m_we, m_fp;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  initial begin
    idle = st(0, 0,0,0,0, 0,0,0,0, 0,0,0);
`ifdef WBARB_PERF_EN
    bus0.hold = 0; bus0.pipe_valid = 0; bus0.pipe_rd = 0; bus0.pipe_fp = 0; bus0.pipe_data = 0;
    bus0.fpu_valid = 0; bus0.fpu_rd = 0; bus0.fpu_fp = 0; bus0.fpu_data = 0;
    bus0.mdu_valid = 0; bus0.mdu_rd = 0; bus0.mdu_data = 0;
`endif

    // Sequential vector table starting from reset (wait=0, rr prefers FPU)
    vecs[0]  = mk(st(0, 1,5,0,32'hDEADBEEF, 0,0,0,0, 0,0,0),                           3'b000, 1,5,0,32'hDEADBEEF);
    vecs[1]  = mk(st(0, 0,0,0,0, 1,3,1,32'h11111111, 1,7,32'h22222222),                3'b010, 1,3,1,32'h11111111);
    vecs[2]  = mk(st(0, 0,0,0,0, 1,4,0,32'h33333333, 1,7,32'h22222222),                3'b001, 1,7,0,32'h22222222);
    vecs[3]  = mk(st(0, 0,0,0,0, 1,4,0,32'h33333333, 1,0,32'h44444444),                3'b010, 1,4,0,32'h33333333);
    vecs[4]  = mk(st(0, 0,0,0,0, 0,0,0,0, 1,0,32'h44444444),                           3'b001, 0,0,0,32'h44444444);
    vecs[5]  = mk(st(0, 0,0,0,0, 1,0,1,32'h55555555, 0,0,0),                           3'b010, 1,0,1,32'h55555555);
    vecs[6]  = mk(st(1, 1,9,0,32'h66666666, 1,10,0,32'h77777777, 1,11,32'h88888888),   3'b000, 0,0,1,32'h55555555);
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = mk(st(0, 1,9,0,32'h66666666, 1,10,0,32'h77777777, 1,11,32'h88888888),   3'b000, 1,9,0,32'h66666666);
    vecs[10] = mk(st(0, 1,12,1,32'h99999999, 1,10,0,32'h77777777, 1,11,32'h88888888),  3'b000, 1,12,1,32'h99999999);
    vecs[11] = mk(st(0, 0,0,0,0, 1,10,0,32'h77777777, 1,11,32'h88888888),              3'b001, 1,11,0,32'h88888888);

    do_reset();
    chk("reset rf_we",    64'(bus.rf_we),    64'd0);
    chk("reset rf_rd",    64'(bus.rf_rd),    64'd0);
    chk("reset rf_fp",    64'(bus.rf_fp),    64'd0);
    chk("reset rf_wdata", 64'(bus.rf_wdata), 64'd0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].s);
      #1;
      chk($sformatf("vec%0d comb", i), 64'(get_comb()), 64'(vecs[i].e_comb));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rf", i), 64'(get_rf()), 64'(vecs[i].e_rf));
    end

    // Starvation: pipe always valid, FPU always pending; FPU forced every 9th cycle
    do_reset();
    p = 0;
    k = 0;
    for (int c = 0; c < 18; c++) begin
      pd = 32'h0000_0100 + 32'(p);
      fd = 32'hF000_0000 + 32'(k);
      drive(st(0, 1,1,0,pd, 1,6,0,fd, 0,0,0));
      exp_b = (c == 8) || (c == 17);
      #1;
      chk($sformatf("starve c%0d comb", c), 64'(get_comb()), 64'({exp_b, exp_b, 1'b0}));
      @(posedge clk);
      #1;
      chk($sformatf("starve c%0d rf", c), 64'(get_rf()),
          exp_b ? 64'({1'b1, 5'd6, 1'b0, fd}) : 64'({1'b1, 5'd1, 1'b0, pd}));
      if (exp_b) k++;
      else p++;
    end

    // Randomized traffic against the reference model
    do_reset();
    m_wait = 0; m_ptr = 0; m_we = 0; m_fp = 0; m_rd = 0; m_data = 0;
    p_keep = 0; f_keep = 0; m_keep = 0;
    s = idle;
    for (int c = 0; c < 500; c++) begin
      s.hold = ($urandom_range(0, 7) == 0);
      if (!p_keep) begin
        s.pv = ($urandom_range(0, 4) != 0);
        s.prd = 5'($urandom_range(0, 3)); s.pfp = 1'($urandom); s.pdata = $urandom;
      end
      if (!f_keep) begin
        s.fv = ($urandom_range(0, 2) == 0);
        s.frd = 5'($urandom_range(0, 3)); s.ffp = 1'($urandom); s.fdata = $urandom;
      end
      if (!m_keep) begin
        s.mv = ($urandom_range(0, 2) == 0);
        s.mrd = 5'($urandom_range(0, 3)); s.mdata = $urandom;
      end
      m_force = (m_wait >= LIMIT) && (s.fv || s.mv);
      src = 0;
      if (!s.hold) begin
        if (s.pv && !m_force) src = 1;
        else if (s.fv && s.mv) src = (m_ptr == 0) ? 2 : 3;
        else if (s.fv) src = 2;
        else if (s.mv) src = 3;
      end
      drive(s);
      #1;
      chk($sformatf("rand c%0d comb", c), 64'(get_comb()),
          64'({(!s.hold && s.pv && m_force), (src == 2), (src == 3)}));
      @(posedge clk);
      #1;
      if (!s.hold) begin
        if (src >= 2 || !(s.fv || s.mv)) m_wait = 0;
        else if (m_wait < 255) m_wait++;
        if (src == 2) m_ptr = 1;
        else if (src == 3) m_ptr = 0;
      end
      if (src == 0) m_we = 0;
      else begin
        if (src == 1) begin m_rd = s.prd; m_fp = s.pfp; m_data = s.pdata; end
        else if (src == 2) begin m_rd = s.frd; m_fp = s.ffp; m_data = s.fdata; end
        else begin m_rd = s.mrd; m_fp = 1'b0; m_data = s.mdata; end
        m_we = m_fp || (m_rd != 5'd0);
      end
      chk($sformatf("rand c%0d rf", c), 64'(get_rf()), 64'({m_we, m_rd, m_fp, m_data}));
      p_keep = s.pv && (src != 1);
      f_keep = s.fv && (src != 2);
      m_keep = s.mv && (src != 3);
    end

    // Asynchronous reset mid-cycle while aux results are pending
    drive(st(0, 1,7,1,32'hCAFEF00D, 1,5,1,32'h12345678, 1,9,32'h9ABCDEF0));
    @(posedge clk);
    #3;
    Rst = 1'b1;
    #1;
    chk("async reset rf", 64'(get_rf()), 64'd0);
    drive(idle);
    @(posedge clk);
    #1;
    chk("reset held rf", 64'(get_rf()), 64'd0);
    Rst = 1'b0;

`ifdef WBARB_PERF_EN
    // STARVE_LIMIT=0 instance: pipe and MDU always valid
    do_reset();
    bus0.pipe_valid = 1; bus0.pipe_rd = 5'd2; bus0.pipe_data = 32'hAAAA0000;
    bus0.mdu_valid = 1; bus0.mdu_rd = 5'd3; bus0.mdu_data = 32'hBBBB0000;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("perf c%0d stall", c), 64'(bus0.pipe_stall), 64'd1);
      @(posedge clk);
      #1;
    end
    chk("perf count", 64'(bus0.perf_stall_cnt), 64'd10);
    chk("perf rf", 64'({bus0.rf_we, bus0.rf_rd, bus0.rf_wdata}), 64'({1'b1, 5'd3, 32'hBBBB0000}));
    #2;
    Rst = 1'b1;
    #1;
    chk("perf async reset cnt", 64'(bus0.perf_stall_cnt), 64'd0);
    chk("perf async reset rf", 64'({bus0.rf_we, bus0.rf_rd, bus0.rf_fp, bus0.rf_wdata}), 64'd0);
    bus0.pipe_valid = 0;
    bus0.mdu_valid = 0;
    @(posedge clk);
    #1;
    Rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
